pong_ball_engine: RTL

Ball motion engine for the single-paddle pong display. It feeds the per-pixel renderer: the renderer receives the ball centre (ball_x, ball_y) and draws the radius-RADIUS disc, and it supplies the current paddle rectangle. The engine owns the frame-rate tick divider, wall and paddle reflection, miss detection and serve sequencing, so the renderer holds no motion state.

---
 rtl/pong_ball_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pong_ball_engine.sv
// Ball motion engine for the single-paddle pong display: tick divider, wall/paddle
// reflection, miss detection and serve sequencing. Renderer consumes ball_x/ball_y.
module pong_ball_engine #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int RADIUS      = 10,
  parameter int SPEED       = 1,
  parameter int TICK_DIV    = 1000000,
  parameter int START_X     = 330,
  parameter int START_Y     = 240,
  parameter int SERVE_DELAY = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       serve,
  input  logic [9:0] paddle_left,
  input  logic [9:0] paddle_right,
  input  logic [8:0] paddle_top,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic       pos_update,
  output logic       miss,
  output logic [1:0] state,
  output logic [7:0] bounces
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  localparam int DLY_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [23:0]      TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(SERVE_DELAY - 1);
  localparam logic [10:0]      SPD       = 11'(SPEED);
  localparam logic [10:0]      RAD       = 11'(RADIUS);
  localparam logic [10:0]      X_MAX     = 11'(WIDTH - 1 - RADIUS);
  localparam logic [10:0]      Y_MAX     = 11'(HEIGHT - 1 - RADIUS);
  localparam logic [10:0]      LO_TURN   = 11'(RADIUS + SPEED);
  localparam logic [9:0]       HOME_X    = 10'(START_X);
  localparam logic [8:0]       HOME_Y    = 9'(START_Y);

  logic [23:0]      cnt_reg;
  logic [DLY_W-1:0] dly_reg;
  logic [1:0]       state_reg;
  logic [9:0]       ball_x_reg, ball_x_next;
  logic [8:0]       ball_y_reg, ball_y_next;
  logic             dx_reg, dx_next;
  logic             dy_reg, dy_next;
  logic             serve_dir_reg;
  logic             pos_update_reg;
  logic             miss_reg;
  logic [7:0]       bounces_reg;

  logic        tick;
  logic        hit;
  logic        floor_hit;
  logic [10:0] bx, by, pt, pl, pr;

  // 11-bit unsigned intermediates so no comparison or sum can wrap
  assign bx = {1'b0, ball_x_reg};
  assign by = {2'b00, ball_y_reg};
  assign pt = {2'b00, paddle_top};
  assign pl = {1'b0, paddle_left};
  assign pr = {1'b0, paddle_right};

  assign tick      = (cnt_reg == TICK_LAST);
  assign hit       = dy_reg && (by + RAD <= pt) && (by + RAD + SPD >= pt) &&
                     (bx >= pl) && (bx <= pr);
  assign floor_hit = dy_reg && !hit && (by + SPD >= Y_MAX);

  always_comb begin
    ball_x_next = ball_x_reg;
    dx_next     = dx_reg;
    if (dx_reg) begin
      if (bx + SPD >= X_MAX) begin
        ball_x_next = 10'(X_MAX);
        dx_next     = 1'b0;
      end else begin
        ball_x_next = 10'(bx + SPD);
      end
    end else if (bx < LO_TURN) begin
      ball_x_next = 10'(RAD);
      dx_next     = 1'b1;
    end else begin
      ball_x_next = 10'(bx - SPD);
    end

    ball_y_next = ball_y_reg;
    dy_next     = dy_reg;
    if (!dy_reg) begin
      if (by < LO_TURN) begin
        ball_y_next = 9'(RAD);
        dy_next     = 1'b1;
      end else begin
        ball_y_next = 9'(by - SPD);
      end
    end else if (hit) begin
      ball_y_next = 9'(pt - RAD);
      dy_next     = 1'b0;
    end else if (floor_hit) begin
      ball_y_next = 9'(Y_MAX);
    end else begin
      ball_y_next = 9'(by + SPD);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_reg        <= '0;
      dly_reg        <= '0;
      state_reg      <= ST_IDLE;
      ball_x_reg     <= HOME_X;
      ball_y_reg     <= HOME_Y;
      dx_reg         <= 1'b1;
      dy_reg         <= 1'b1;
      serve_dir_reg  <= 1'b1;
      pos_update_reg <= 1'b0;
      miss_reg       <= 1'b0;
      bounces_reg    <= '0;
    end else begin
      cnt_reg        <= tick ? '0 : cnt_reg + 24'd1;
      pos_update_reg <= 1'b0;
      miss_reg       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ball_x_reg <= HOME_X;
          ball_y_reg <= HOME_Y;
          if (serve) begin
            state_reg     <= ST_MOVE;
            bounces_reg   <= '0;
            dy_reg        <= 1'b1;
            dx_reg        <= serve_dir_reg;
            serve_dir_reg <= ~serve_dir_reg;
          end
        end
        ST_MOVE: begin
          if (tick) begin
            ball_x_reg     <= ball_x_next;
            ball_y_reg     <= ball_y_next;
            dx_reg         <= dx_next;
            dy_reg         <= dy_next;
            pos_update_reg <= 1'b1;
            if (hit && bounces_reg != 8'hFF)
              bounces_reg <= bounces_reg + 8'd1;
            if (floor_hit) begin
              miss_reg  <= 1'b1;
              state_reg <= ST_MISS;
              dly_reg   <= '0;
            end
          end
        end
        ST_MISS: begin
          // ball stays frozen on the floor until the serve delay expires
          if (tick) begin
            if (dly_reg == DLY_LAST) begin
              state_reg      <= ST_IDLE;
              ball_x_reg     <= HOME_X;
              ball_y_reg     <= HOME_Y;
              dy_reg         <= 1'b1;
              pos_update_reg <= 1'b1;
            end else begin
              dly_reg <= dly_reg + DLY_W'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ball_x     = ball_x_reg;
  assign ball_y     = ball_y_reg;
  assign pos_update = pos_update_reg;
  assign miss       = miss_reg;
  assign state      = state_reg;
  assign bounces    = bounces_reg;

endmodule
